imm_ext_pipe: RTL and testbench

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

---
 rtl/imm_ext_pipe.sv | 117 +++++++++++
 tb/tb_imm_ext_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// Immediate extender with a single-entry output register and valid/ready handshakes.
// Optional PREFIX op enabled by defining IMM_EXT_PREFIX_EN.
module imm_ext_pipe #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int SHAMT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] imm,
    input  logic [2:0]       ext_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] imm_out,
    output logic             op_err
);

    localparam int PW = OUT_W - IMM_W;

    localparam logic [2:0] OP_ZERO   = 3'd0;
    localparam logic [2:0] OP_ZEXT   = 3'd1;
    localparam logic [2:0] OP_SEXT   = 3'd2;
    localparam logic [2:0] OP_LUI    = 3'd3;
    localparam logic [2:0] OP_BRANCH = 3'd4;
`ifdef IMM_EXT_PREFIX_EN
    localparam logic [2:0] OP_PREFIX = 3'd5;
`endif

    logic             accept;
    logic             is_pfx;
    logic             err;
    logic [OUT_W-1:0] res;
    logic [OUT_W-1:0] z_raw;
    logic [OUT_W-1:0] s_raw;
    logic [OUT_W-1:0] zx;
    logic [OUT_W-1:0] sx;

`ifdef IMM_EXT_PREFIX_EN
    logic [PW-1:0] pfx_q;
    logic          pfx_pend;
`endif

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Decode the op and form the extended value, splicing in a pending prefix.
    always_comb begin
        z_raw  = {{PW{1'b0}}, imm};
        s_raw  = {{PW{imm[IMM_W-1]}}, imm};
        zx     = z_raw;
        sx     = s_raw;
        res    = '0;
        err    = 1'b0;
        is_pfx = 1'b0;
`ifdef IMM_EXT_PREFIX_EN
        if (pfx_pend) begin
            zx = {pfx_q, imm};
            sx = {pfx_q, imm};
        end
`endif
        case (ext_op)
            OP_ZERO:   res = '0;
            OP_ZEXT:   res = zx;
            OP_SEXT:   res = sx;
            OP_LUI:    res = z_raw << PW;
            OP_BRANCH: res = sx << SHAMT;
`ifdef IMM_EXT_PREFIX_EN
            OP_PREFIX: is_pfx = 1'b1;
`endif
            default: begin
                res = '0;
                err = 1'b1;
            end
        endcase
    end

    // Output register: load on accept, drain on out_ready, drop on flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            op_err    <= 1'b0;
            imm_out   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept && !is_pfx) begin
            out_valid <= 1'b1;
            imm_out   <= res;
            op_err    <= err;
        end else if (accept || out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef IMM_EXT_PREFIX_EN
    // Prefix store: set by PREFIX, consumed by any other accepted op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pfx_q    <= '0;
            pfx_pend <= 1'b0;
        end else if (flush) begin
            pfx_q    <= '0;
            pfx_pend <= 1'b0;
        end else if (accept) begin
            if (is_pfx) begin
                pfx_q    <= imm[PW-1:0];
                pfx_pend <= 1'b1;
            end else begin
                pfx_pend <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe (default parameters).
// PREFIX scenarios run when IMM_EXT_PREFIX_EN is defined.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [2:0]  ext_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm_out;
    logic        op_err;

    int errs = 0;
    int checks = 0;

    imm_ext_pipe dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .imm      (imm),
        .ext_op   (ext_op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .imm_out  (imm_out),
        .op_err   (op_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] d);
        in_valid = v;
        ext_op   = op;
        imm      = d;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 3'd0, 16'h0);
        #2;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        checks++; if (op_err !== 1'b0) begin errs++; $display("FAIL rst_err got %b exp 0", op_err); end
        checks++; if (imm_out !== 32'h0) begin errs++; $display("FAIL rst_out got %h exp 0", imm_out); end
        tick;
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_sext;
        out_ready = 1'b1;
        drive(1'b1, 3'd2, 16'h8001);
        tick;
        drive(1'b0, 3'd0, 16'h0);
        checks++; if (imm_out !== 32'hFFFF8001) begin errs++; $display("FAIL sext got %h exp FFFF8001", imm_out); end
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL sext_valid got %b exp 1", out_valid); end
        checks++; if (op_err !== 1'b0) begin errs++; $display("FAIL sext_err got %b exp 0", op_err); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL sext_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_branch_lui;
        out_ready = 1'b1;
        drive(1'b1, 3'd4, 16'hFFFF);
        tick;
        drive(1'b1, 3'd3, 16'h1234);
        checks++; if (imm_out !== 32'hFFFFFFFC) begin errs++; $display("FAIL branch got %h exp FFFFFFFC", imm_out); end
        tick;
        drive(1'b1, 3'd0, 16'hFFFF);
        checks++; if (imm_out !== 32'h12340000 || out_valid !== 1'b1) begin errs++; $display("FAIL lui got %h/%b exp 12340000/1", imm_out, out_valid); end
        tick;
        drive(1'b1, 3'd4, 16'h0003);
        checks++; if (imm_out !== 32'h0 || op_err !== 1'b0) begin errs++; $display("FAIL zero got %h/%b exp 0/0", imm_out, op_err); end
        tick;
        drive(1'b0, 3'd0, 16'h0);
        checks++; if (imm_out !== 32'h0000000C) begin errs++; $display("FAIL branch_pos got %h exp 0000000C", imm_out); end
        tick;
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h00AA);
        tick;
        drive(1'b1, 3'd1, 16'h0055);
        for (int k = 0; k < 3; k++) begin
            checks++; if (imm_out !== 32'h000000AA || out_valid !== 1'b1) begin errs++; $display("FAIL stall_hold%0d got %h/%b exp 000000AA/1", k, imm_out, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL stall_ready%0d got %b exp 0", k, in_ready); end
            tick;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stall_release got %b exp 1", in_ready); end
        tick;
        drive(1'b0, 3'd0, 16'h0);
        checks++; if (imm_out !== 32'h00000055 || out_valid !== 1'b1) begin errs++; $display("FAIL b2b got %h/%b exp 00000055/1", imm_out, out_valid); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_reserved;
        out_ready = 1'b1;
        drive(1'b1, 3'd7, 16'h1234);
        tick;
        drive(1'b1, 3'd6, 16'hFFFF);
        checks++; if (imm_out !== 32'h0 || op_err !== 1'b1) begin errs++; $display("FAIL op7 got %h/%b exp 0/1", imm_out, op_err); end
        tick;
`ifndef IMM_EXT_PREFIX_EN
        drive(1'b1, 3'd5, 16'hDEAD);
        checks++; if (imm_out !== 32'h0 || op_err !== 1'b1) begin errs++; $display("FAIL op6 got %h/%b exp 0/1", imm_out, op_err); end
        tick;
        drive(1'b1, 3'd1, 16'h0009);
        checks++; if (imm_out !== 32'h0 || op_err !== 1'b1 || out_valid !== 1'b1) begin errs++; $display("FAIL op5 got %h/%b exp 0/1", imm_out, op_err); end
`else
        drive(1'b1, 3'd1, 16'h0009);
        checks++; if (imm_out !== 32'h0 || op_err !== 1'b1) begin errs++; $display("FAIL op6 got %h/%b exp 0/1", imm_out, op_err); end
`endif
        tick;
        drive(1'b0, 3'd0, 16'h0);
        checks++; if (imm_out !== 32'h00000009 || op_err !== 1'b0) begin errs++; $display("FAIL err_clear got %h/%b exp 00000009/0", imm_out, op_err); end
        tick;
    endtask

`ifdef IMM_EXT_PREFIX_EN
    task automatic test_prefix;
        out_ready = 1'b1;
        drive(1'b1, 3'd5, 16'hDEAD);
        tick;
        drive(1'b1, 3'd1, 16'hBEEF);
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL pfx_noout got %b exp 0", out_valid); end
        tick;
        drive(1'b1, 3'd1, 16'h0001);
        checks++; if (imm_out !== 32'hDEADBEEF || out_valid !== 1'b1) begin errs++; $display("FAIL pfx_zext got %h/%b exp DEADBEEF/1", imm_out, out_valid); end
        tick;
        drive(1'b1, 3'd5, 16'h0012);
        checks++; if (imm_out !== 32'h00000001) begin errs++; $display("FAIL pfx_used got %h exp 00000001", imm_out); end
        tick;
        drive(1'b1, 3'd4, 16'h8000);
        tick;
        drive(1'b1, 3'd5, 16'h7777);
        checks++; if (imm_out !== 32'h004A0000) begin errs++; $display("FAIL pfx_branch got %h exp 004A0000", imm_out); end
        tick;
        drive(1'b1, 3'd3, 16'h0003);
        tick;
        drive(1'b1, 3'd2, 16'h8004);
        checks++; if (imm_out !== 32'h00030000) begin errs++; $display("FAIL pfx_lui got %h exp 00030000", imm_out); end
        tick;
        drive(1'b0, 3'd0, 16'h0);
        checks++; if (imm_out !== 32'hFFFF8004) begin errs++; $display("FAIL pfx_dropped got %h exp FFFF8004", imm_out); end
        tick;
    endtask
`endif

    task automatic test_flush;
        out_ready = 1'b1;
`ifdef IMM_EXT_PREFIX_EN
        drive(1'b1, 3'd5, 16'h1111);
        tick;
        drive(1'b0, 3'd0, 16'h0);
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fl_pfx got %b exp 0", out_valid); end
`endif
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h0033);
        tick;
        out_ready = 1'b1;
        flush = 1'b1;
        drive(1'b1, 3'd1, 16'h0044);
        #1;
        checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fl_ready got %b exp 0", in_ready); end
        tick;
        flush = 1'b0;
        drive(1'b0, 3'd0, 16'h0);
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fl_valid got %b exp 0", out_valid); end
        drive(1'b1, 3'd1, 16'h0002);
        tick;
        drive(1'b0, 3'd0, 16'h0);
        checks++; if (imm_out !== 32'h00000002 || out_valid !== 1'b1) begin errs++; $display("FAIL fl_after got %h/%b exp 00000002/1", imm_out, out_valid); end
        tick;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h0777);
        tick;
        drive(1'b0, 3'd0, 16'h0);
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL rm_pre got %b exp 1", out_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || imm_out !== 32'h0) begin errs++; $display("FAIL rm_async got %h/%b exp 0/0", imm_out, out_valid); end
        tick;
        reset = 1'b0;
        tick;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL rm_after got %b/%b exp 0/1", out_valid, in_ready); end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset;
        test_sext;
        test_branch_lui;
        test_stall;
        test_reserved;
`ifdef IMM_EXT_PREFIX_EN
        test_prefix;
`endif
        test_flush;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
